// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_pkg
// Description : Shared opcodes, instruction field positions and dispatch
//               state encodings for the dispatch/rename slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    // Opcodes; anything else is consumed as a NOP
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions within the 16-bit instruction word
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RA_MSB = 7;
    localparam int RA_LSB = 4;
    localparam int RB_MSB = 3;
    localparam int RB_LSB = 0;

    // Dispatch state encodings
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dispatch_rename_if.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_rename_if
// Description : Instruction-buffer, fetch-redirect, CDB, RS-release and
//               issue signals between dispatch and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface dispatch_rename_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2,
    parameter int IB_W   = 32
);
    logic              ib_empty;
    logic [IB_W-1:0]   ib_data;
    logic              ib_pop;
    logic              ib_flush;
    logic              branch_taken;
    logic [15:0]       branch_target;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              rs_release;
    logic [TAG_W-1:0]  rs_release_slot;
    logic              iss_valid;
    logic [TAG_W-1:0]  iss_slot;
    logic [3:0]        iss_op;
    logic [3:0]        iss_rd;
    logic              iss_a_ready;
    logic              iss_b_ready;
    logic [TAG_W-1:0]  iss_a_tag;
    logic [TAG_W-1:0]  iss_b_tag;
    logic [DATA_W-1:0] iss_a_val;
    logic [DATA_W-1:0] iss_b_val;

    // Dispatch side
    modport master (
        input  ib_empty, ib_data, cdb_valid, cdb_tag, cdb_value,
               rs_release, rs_release_slot,
        output ib_pop, ib_flush, branch_taken, branch_target,
               iss_valid, iss_slot, iss_op, iss_rd, iss_a_ready, iss_b_ready,
               iss_a_tag, iss_b_tag, iss_a_val, iss_b_val
    );

    // Instruction buffer / RS array / CDB side
    modport slave (
        output ib_empty, ib_data, cdb_valid, cdb_tag, cdb_value,
               rs_release, rs_release_slot,
        input  ib_pop, ib_flush, branch_taken, branch_target,
               iss_valid, iss_slot, iss_op, iss_rd, iss_a_ready, iss_b_ready,
               iss_a_tag, iss_b_tag, iss_a_val, iss_b_val
    );
endinterface
`default_nettype wire

// File: rtl/reg_status_table.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_table
// Description : Per-register busy/tag/value table with two renaming read
//               ports (CDB bypass), a debug read port, one dispatch write
//               port and CDB wakeup. A dispatch write beats a same-cycle CDB
//               update of the same register.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_status_table #(
    parameter int NREGS  = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_value,
    input  logic              i_wr_en,
    input  logic [3:0]        i_wr_idx,
    input  logic              i_wr_busy,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_val,
    input  logic [3:0]        i_rd_a_idx,
    input  logic [3:0]        i_rd_b_idx,
    input  logic [3:0]        i_dbg_idx,
    output logic              o_rd_a_ready,
    output logic [TAG_W-1:0]  o_rd_a_tag,
    output logic [DATA_W-1:0] o_rd_a_val,
    output logic              o_rd_b_ready,
    output logic [TAG_W-1:0]  o_rd_b_tag,
    output logic [DATA_W-1:0] o_rd_b_val,
    output logic              o_dbg_busy,
    output logic [DATA_W-1:0] o_dbg_val
);

    typedef struct packed {
        logic              ready;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rd_port_t;

    logic              r_busy [NREGS];
    logic [TAG_W-1:0]  r_tag  [NREGS];
    logic [DATA_W-1:0] r_val  [NREGS];

    // Out-of-range indices read as a ready zero; the safe index keeps the
    // array access in bounds while the ok flag masks the result.
    function automatic rd_port_t f_read(
        input logic              ok,
        input logic              busy,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] val,
        input logic              cdb_v,
        input logic [TAG_W-1:0]  cdb_t,
        input logic [DATA_W-1:0] cdb_val
    );
        rd_port_t res;
        res = '{ready: 1'b1, tag: '0, val: '0};
        if (ok) begin
            res.tag = tag;
            res.val = val;
            if (busy) begin
                if (cdb_v && cdb_t == tag) res.val = cdb_val;
                else                       res.ready = 1'b0;
            end
        end
        return res;
    endfunction

    logic       w_a_ok, w_b_ok, w_dbg_ok;
    logic [3:0] w_a_safe, w_b_safe, w_dbg_safe;
    rd_port_t   w_a, w_b;

    assign w_a_ok     = int'(i_rd_a_idx) < NREGS;
    assign w_b_ok     = int'(i_rd_b_idx) < NREGS;
    assign w_dbg_ok   = int'(i_dbg_idx)  < NREGS;
    assign w_a_safe   = w_a_ok   ? i_rd_a_idx : 4'd0;
    assign w_b_safe   = w_b_ok   ? i_rd_b_idx : 4'd0;
    assign w_dbg_safe = w_dbg_ok ? i_dbg_idx  : 4'd0;

    assign w_a = f_read(w_a_ok, r_busy[w_a_safe], r_tag[w_a_safe], r_val[w_a_safe],
                        i_cdb_valid, i_cdb_tag, i_cdb_value);
    assign w_b = f_read(w_b_ok, r_busy[w_b_safe], r_tag[w_b_safe], r_val[w_b_safe],
                        i_cdb_valid, i_cdb_tag, i_cdb_value);

    assign o_rd_a_ready = w_a.ready;
    assign o_rd_a_tag   = w_a.tag;
    assign o_rd_a_val   = w_a.val;
    assign o_rd_b_ready = w_b.ready;
    assign o_rd_b_tag   = w_b.tag;
    assign o_rd_b_val   = w_b.val;
    assign o_dbg_busy   = w_dbg_ok ? r_busy[w_dbg_safe] : 1'b0;
    assign o_dbg_val    = w_dbg_ok ? r_val[w_dbg_safe]  : '0;

    // Table update: dispatch write first (newest producer), else CDB wakeup
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
                r_val[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_wr_en && int'(i_wr_idx) == i) begin
                    r_busy[i] <= i_wr_busy;
                    r_tag[i]  <= i_wr_tag;
                    if (!i_wr_busy) r_val[i] <= i_wr_val;
                end else if (i_cdb_valid && r_busy[i] && r_tag[i] == i_cdb_tag) begin
                    r_busy[i] <= 1'b0;
                    r_val[i]  <= i_cdb_value;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_rename.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_rename
// Description : Pops the show-ahead instruction buffer, renames sources via
//               the register status table, allocates RS slots, issues
//               operand packets, redirects fetch on JMP and stops on HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_rename
    import dispatch_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int DATA_W = 16,
    parameter int NUM_RS = 4,
    parameter int TAG_W  = 2,
    parameter int IB_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    dispatch_rename_if.master bus,
    output logic              halted,
    input  logic [3:0]        dbg_idx,
    output logic              dbg_busy,
    output logic [DATA_W-1:0] dbg_val
);

    logic [1:0]        r_state, w_state_nxt;
    logic [NUM_RS-1:0] r_alloc_mask;      // 1 = slot held by an in-flight op
    logic [NUM_RS-1:0] w_alloc_set, w_release_clr;
    logic              w_free_any;
    logic [TAG_W-1:0]  w_free_slot;

    logic [15:0] w_instr;
    logic        w_unused_pc;
    logic [3:0]  w_op, w_rd, w_ra, w_rb;
    logic        w_is_add, w_is_movi, w_is_jmp, w_is_halt, w_fire;

    logic              w_a_ready, w_b_ready;
    logic [TAG_W-1:0]  w_a_tag, w_b_tag;
    logic [DATA_W-1:0] w_a_val, w_b_val;

    logic              r_iss_valid, r_iss_a_ready, r_iss_b_ready;
    logic [TAG_W-1:0]  r_iss_slot, r_iss_a_tag, r_iss_b_tag;
    logic [3:0]        r_iss_op, r_iss_rd;
    logic [DATA_W-1:0] r_iss_a_val, r_iss_b_val;
    logic              r_branch_taken, r_ib_flush;
    logic [15:0]       r_branch_target;

    assign w_instr     = bus.ib_data[15:0];
    assign w_unused_pc = ^bus.ib_data[IB_W-1:16];
    assign w_op        = w_instr[OP_MSB:OP_LSB];
    assign w_rd        = w_instr[RD_MSB:RD_LSB];
    assign w_ra        = w_instr[RA_MSB:RA_LSB];
    assign w_rb        = w_instr[RB_MSB:RB_LSB];
    assign w_is_add    = (w_op == OP_ADD);
    assign w_is_movi   = (w_op == OP_MOVI);
    assign w_is_jmp    = (w_op == OP_JMP);
    assign w_is_halt   = (w_op == OP_HALT);

    // Lowest-index free slot from the mask registered at the start of cycle
    always_comb begin
        w_free_any  = 1'b0;
        w_free_slot = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!r_alloc_mask[i]) begin
                w_free_any  = 1'b1;
                w_free_slot = TAG_W'(i);
            end
        end
    end

    // Pop is suppressed during reset so every output reads zero then
    assign w_fire     = !reset && (r_state == ST_RUN) && !bus.ib_empty &&
                        (!w_is_add || w_free_any);
    assign bus.ib_pop = w_fire;

    assign w_alloc_set   = (w_fire && w_is_add) ? (NUM_RS'(1) << w_free_slot) : '0;
    assign w_release_clr = bus.rs_release ? (NUM_RS'(1) << bus.rs_release_slot) : '0;

    // Next-state: JMP detours through one REDIRECT cycle, HALT is sticky
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_fire && w_is_jmp)       w_state_nxt = ST_REDIRECT;
                else if (w_fire && w_is_halt) w_state_nxt = ST_HALTED;
            end
            ST_REDIRECT: w_state_nxt = ST_RUN;
            ST_HALTED:   w_state_nxt = ST_HALTED;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    // State register and RS slot occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_alloc_mask <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_alloc_mask <= (r_alloc_mask & ~w_release_clr) | w_alloc_set;
        end
    end

    reg_status_table #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_rst (
        .clk          (clk),
        .rst          (reset),
        .i_cdb_valid  (bus.cdb_valid),
        .i_cdb_tag    (bus.cdb_tag),
        .i_cdb_value  (bus.cdb_value),
        .i_wr_en      (w_fire && (w_is_add || w_is_movi)),
        .i_wr_idx     (w_rd),
        .i_wr_busy    (w_is_add),
        .i_wr_tag     (w_free_slot),
        .i_wr_val     (DATA_W'(w_instr[7:0])),
        .i_rd_a_idx   (w_ra),
        .i_rd_b_idx   (w_rb),
        .i_dbg_idx    (dbg_idx),
        .o_rd_a_ready (w_a_ready),
        .o_rd_a_tag   (w_a_tag),
        .o_rd_a_val   (w_a_val),
        .o_rd_b_ready (w_b_ready),
        .o_rd_b_tag   (w_b_tag),
        .o_rd_b_val   (w_b_val),
        .o_dbg_busy   (dbg_busy),
        .o_dbg_val    (dbg_val)
    );

    // Issue packet and fetch redirect; issue fields hold between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_valid     <= 1'b0;
            r_iss_slot      <= '0;
            r_iss_op        <= '0;
            r_iss_rd        <= '0;
            r_iss_a_ready   <= 1'b0;
            r_iss_b_ready   <= 1'b0;
            r_iss_a_tag     <= '0;
            r_iss_b_tag     <= '0;
            r_iss_a_val     <= '0;
            r_iss_b_val     <= '0;
            r_branch_taken  <= 1'b0;
            r_ib_flush      <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_iss_valid    <= w_fire && w_is_add;
            r_branch_taken <= w_fire && w_is_jmp;
            r_ib_flush     <= w_fire && w_is_jmp;
            if (w_fire && w_is_jmp) r_branch_target <= {4'd0, w_instr[11:0]};
            if (w_fire && w_is_add) begin
                r_iss_slot    <= w_free_slot;
                r_iss_op      <= w_op;
                r_iss_rd      <= w_rd;
                r_iss_a_ready <= w_a_ready;
                r_iss_b_ready <= w_b_ready;
                r_iss_a_tag   <= w_a_tag;
                r_iss_b_tag   <= w_b_tag;
                r_iss_a_val   <= w_a_val;
                r_iss_b_val   <= w_b_val;
            end
        end
    end

    assign bus.iss_valid     = r_iss_valid;
    assign bus.iss_slot      = r_iss_slot;
    assign bus.iss_op        = r_iss_op;
    assign bus.iss_rd        = r_iss_rd;
    assign bus.iss_a_ready   = r_iss_a_ready;
    assign bus.iss_b_ready   = r_iss_b_ready;
    assign bus.iss_a_tag     = r_iss_a_tag;
    assign bus.iss_b_tag     = r_iss_b_tag;
    assign bus.iss_a_val     = r_iss_a_val;
    assign bus.iss_b_val     = r_iss_b_val;
    assign bus.branch_taken  = r_branch_taken;
    assign bus.ib_flush      = r_ib_flush;
    assign bus.branch_target = r_branch_target;
    assign halted            = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_dispatch_rename.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_rename
// Description : Directed self-checking bench for dispatch_rename.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_rename;
    import dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dbg_idx = 4'd0;
    logic        dbg_busy;
    logic [15:0] dbg_val;
    logic        halted;
    int          checks = 0;
    int          failures = 0;

    dispatch_rename_if #(.DATA_W(16), .TAG_W(2), .IB_W(32)) bus ();

    dispatch_rename #(
        .NREGS(16), .DATA_W(16), .NUM_RS(4), .TAG_W(2), .IB_W(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .halted   (halted),
        .dbg_idx  (dbg_idx),
        .dbg_busy (dbg_busy),
        .dbg_val  (dbg_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_add(input logic [3:0] rd, ra, rb);
        return {16'h1000, OP_ADD, rd, ra, rb};
    endfunction
    function automatic logic [31:0] f_movi(input logic [3:0] rd, input logic [7:0] imm);
        return {16'h1000, OP_MOVI, rd, imm};
    endfunction
    function automatic logic [31:0] f_jmp(input logic [11:0] tgt);
        return {16'h1000, OP_JMP, tgt};
    endfunction
    function automatic logic [31:0] f_halt();
        return {16'h1000, OP_HALT, 12'h000};
    endfunction

    // Advance one clock; leave time 1 unit after the edge; clear pulse inputs
    task automatic tick();
        @(posedge clk);
        #1;
        bus.cdb_valid  = 1'b0;
        bus.rs_release = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ib_empty = 1'b1;
        bus.ib_data = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        bus.cdb_value = '0;
        bus.rs_release = 1'b0;
        bus.rs_release_slot = '0;
        dbg_idx = 4'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        bus.ib_empty = 1'b0;
        bus.ib_data = f_movi(4'd1, 8'h11);
        #1;
        checks++; if (bus.ib_pop !== 1'b0) begin failures++; $display("FAIL rst_pop: got %b want 0", bus.ib_pop); end
        tick();
        reset = 1'b0;
        bus.ib_empty = 1'b1;
        dbg_idx = 4'd1;
        #1;
        checks++; if (bus.ib_flush !== 1'b0 || bus.branch_taken !== 1'b0) begin failures++; $display("FAIL rst_redirect: got flush=%b taken=%b want 0 0", bus.ib_flush, bus.branch_taken); end
        checks++; if (bus.branch_target !== 16'h0) begin failures++; $display("FAIL rst_target: got %h want 0000", bus.branch_target); end
        checks++; if (bus.iss_valid !== 1'b0 || bus.iss_slot !== 2'd0 || bus.iss_a_val !== 16'h0) begin failures++; $display("FAIL rst_issue: got v=%b slot=%0d a=%h want 0 0 0", bus.iss_valid, bus.iss_slot, bus.iss_a_val); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b want 0", halted); end
        checks++; if (dbg_busy !== 1'b0 || dbg_val !== 16'h0) begin failures++; $display("FAIL rst_table: got busy=%b val=%h want 0 0000", dbg_busy, dbg_val); end
    endtask

    task automatic test_movi_add();
        do_reset();
        bus.ib_empty = 1'b0;
        bus.ib_data = f_movi(4'd1, 8'd5);
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL movi_pop: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_data = f_movi(4'd2, 8'd7);
        tick();
        bus.ib_data = f_add(4'd3, 4'd1, 4'd2);
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL add_pop: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_empty = 1'b1;
        dbg_idx = 4'd3;
        #1;
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_slot !== 2'd0 || bus.iss_rd !== 4'd3 || bus.iss_op !== OP_ADD) begin failures++; $display("FAIL add_issue: got v=%b slot=%0d rd=%0d op=%h want 1 0 3 0", bus.iss_valid, bus.iss_slot, bus.iss_rd, bus.iss_op); end
        checks++; if (bus.iss_a_ready !== 1'b1 || bus.iss_b_ready !== 1'b1 || bus.iss_a_val !== 16'd5 || bus.iss_b_val !== 16'd7) begin failures++; $display("FAIL add_operands: got ar=%b br=%b a=%0d b=%0d want 1 1 5 7", bus.iss_a_ready, bus.iss_b_ready, bus.iss_a_val, bus.iss_b_val); end
        checks++; if (dbg_busy !== 1'b1) begin failures++; $display("FAIL add_rd_busy: got %b want 1", dbg_busy); end
        tick();
        checks++; if (bus.iss_valid !== 1'b0 || bus.iss_slot !== 2'd0 || bus.iss_a_val !== 16'd5) begin failures++; $display("FAIL issue_hold: got v=%b slot=%0d a=%0d want 0 0 5", bus.iss_valid, bus.iss_slot, bus.iss_a_val); end
    endtask

    task automatic test_dependency();
        do_reset();
        bus.ib_empty = 1'b0;
        bus.ib_data = f_movi(4'd1, 8'd5);
        tick();
        bus.ib_data = f_add(4'd3, 4'd1, 4'd1);
        tick();
        bus.ib_data = f_add(4'd4, 4'd3, 4'd1);
        tick();
        checks++; if (bus.iss_slot !== 2'd1 || bus.iss_a_ready !== 1'b0 || bus.iss_a_tag !== 2'd0) begin failures++; $display("FAIL dep_a: got slot=%0d ar=%b atag=%0d want 1 0 0", bus.iss_slot, bus.iss_a_ready, bus.iss_a_tag); end
        checks++; if (bus.iss_b_ready !== 1'b1 || bus.iss_b_val !== 16'd5) begin failures++; $display("FAIL dep_b: got br=%b b=%0d want 1 5", bus.iss_b_ready, bus.iss_b_val); end
        bus.ib_empty = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 2'd0;
        bus.cdb_value = 16'd12;
        tick();
        dbg_idx = 4'd3;
        #1;
        checks++; if (dbg_busy !== 1'b0 || dbg_val !== 16'd12) begin failures++; $display("FAIL cdb_wakeup: got busy=%b val=%0d want 0 12", dbg_busy, dbg_val); end
        bus.ib_empty = 1'b0;
        bus.ib_data = f_add(4'd3, 4'd1, 4'd1);
        tick();
        bus.ib_data = f_add(4'd5, 4'd3, 4'd1);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 2'd2;
        bus.cdb_value = 16'd12;
        tick();
        bus.ib_empty = 1'b1;
        #1;
        checks++; if (bus.iss_slot !== 2'd3 || bus.iss_a_ready !== 1'b1 || bus.iss_a_val !== 16'd12) begin failures++; $display("FAIL cdb_bypass: got slot=%0d ar=%b a=%0d want 3 1 12", bus.iss_slot, bus.iss_a_ready, bus.iss_a_val); end
        checks++; if (dbg_busy !== 1'b0 || dbg_val !== 16'd12) begin failures++; $display("FAIL bypass_table: got busy=%b val=%0d want 0 12", dbg_busy, dbg_val); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.ib_empty = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.ib_data = f_add(4'(k + 1), 4'd0, 4'd0);
            #1;
            checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL b2b_pop%0d: got %b want 1", k, bus.ib_pop); end
            tick();
            checks++; if (bus.iss_valid !== 1'b1 || bus.iss_slot !== 2'(k)) begin failures++; $display("FAIL b2b_slot%0d: got v=%b slot=%0d want 1 %0d", k, bus.iss_valid, bus.iss_slot, k); end
        end
        bus.ib_data = f_add(4'd5, 4'd0, 4'd0);
        bus.rs_release = 1'b1;
        bus.rs_release_slot = 2'd2;
        #1;
        checks++; if (bus.ib_pop !== 1'b0) begin failures++; $display("FAIL full_stall: got pop=%b want 0", bus.ib_pop); end
        tick();
        checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL stall_no_issue: got %b want 0", bus.iss_valid); end
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL release_pop: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_empty = 1'b1;
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_slot !== 2'd2) begin failures++; $display("FAIL release_slot: got v=%b slot=%0d want 1 2", bus.iss_valid, bus.iss_slot); end
    endtask

    task automatic test_jmp();
        do_reset();
        bus.ib_empty = 1'b0;
        bus.ib_data = f_jmp(12'h004);
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL jmp_pop: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_data = f_movi(4'd1, 8'd3);
        #1;
        checks++; if (bus.branch_taken !== 1'b1 || bus.ib_flush !== 1'b1 || bus.branch_target !== 16'h0004) begin failures++; $display("FAIL jmp_redirect: got taken=%b flush=%b tgt=%h want 1 1 0004", bus.branch_taken, bus.ib_flush, bus.branch_target); end
        checks++; if (bus.ib_pop !== 1'b0) begin failures++; $display("FAIL redirect_pop: got %b want 0", bus.ib_pop); end
        tick();
        #1;
        checks++; if (bus.branch_taken !== 1'b0 || bus.ib_flush !== 1'b0) begin failures++; $display("FAIL redirect_len: got taken=%b flush=%b want 0 0", bus.branch_taken, bus.ib_flush); end
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL after_redirect_pop: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_empty = 1'b1;
        dbg_idx = 4'd1;
        #1;
        checks++; if (dbg_val !== 16'd3) begin failures++; $display("FAIL after_redirect_movi: got %0d want 3", dbg_val); end
    endtask

    task automatic test_write_priority();
        do_reset();
        bus.ib_empty = 1'b0;
        bus.ib_data = f_add(4'd3, 4'd0, 4'd0);
        tick();
        bus.ib_data = f_movi(4'd3, 8'd9);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 2'd0;
        bus.cdb_value = 16'd1;
        tick();
        bus.ib_empty = 1'b1;
        dbg_idx = 4'd3;
        #1;
        checks++; if (dbg_busy !== 1'b0 || dbg_val !== 16'd9) begin failures++; $display("FAIL write_over_cdb: got busy=%b val=%0d want 0 9", dbg_busy, dbg_val); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.ib_empty = 1'b0;
        bus.ib_data = f_halt();
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL halt_pop: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_data = f_movi(4'd2, 8'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.ib_pop !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL halted%0d: got pop=%b halted=%b want 0 1", k, bus.ib_pop, halted); end
            tick();
        end
        reset = 1'b1;
        tick();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset: got %b want 0", halted); end
        reset = 1'b0;
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL run_after_reset: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_data = f_jmp(12'h0AB);
        dbg_idx = 4'd2;
        #1;
        checks++; if (dbg_val !== 16'd6) begin failures++; $display("FAIL movi_after_halt: got %0d want 6", dbg_val); end
        tick();
        reset = 1'b1;
        tick();
        #1;
        checks++; if (bus.branch_taken !== 1'b0 || bus.ib_flush !== 1'b0 || bus.branch_target !== 16'h0) begin failures++; $display("FAIL redirect_reset: got taken=%b flush=%b tgt=%h want 0 0 0000", bus.branch_taken, bus.ib_flush, bus.branch_target); end
        checks++; if (dbg_busy !== 1'b0 || dbg_val !== 16'd0) begin failures++; $display("FAIL table_reset: got busy=%b val=%0d want 0 0", dbg_busy, dbg_val); end
        reset = 1'b0;
        bus.ib_data = f_movi(4'd2, 8'd1);
        #1;
        checks++; if (bus.ib_pop !== 1'b1) begin failures++; $display("FAIL run_after_redirect_reset: got %b want 1", bus.ib_pop); end
        tick();
        bus.ib_empty = 1'b1;
    endtask

    initial begin
        test_reset();
        test_movi_add();
        test_dependency();
        test_back_to_back();
        test_jmp();
        test_write_priority();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
